uart_rx_os: RTL and testbench
=============================

UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 8: data bits per frame, legal range 5..8.
REQ-002 SHALL have parameter PARITY_EN, default 0: 1 = a parity bit follows the data bits.
REQ-003 SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits checked per frame, legal values 1 or 2.
REQ-005 SHALL have parameter DIV_W, default 16: width of baud_div.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16: receive FIFO entries, power of two, at least 2.
REQ-007 Port clk, input, 1: system clock; all logic on its rising edge.
REQ-008 Port resetn, input, 1: synchronous active-low reset.
REQ-009 Port uart_rxd, input, 1: asynchronous serial line, idle high.
REQ-010 Port uart_rx_en, input, 1: receiver enable.
REQ-011 Port baud_div, input, DIV_W: oversample tick period minus 1, in clk cycles; one bit = 16 ticks.
REQ-012 Port m_valid, output, 1: FIFO head entry available.
REQ-013 Port m_ready, input, 1: consumer accepts the head entry.
REQ-014 Port m_data, output, PAYLOAD_BITS: head entry data, LSB first on the line.
REQ-015 Port m_perr, output, 1: head entry parity error.
REQ-016 Port m_ferr, output, 1: head entry framing error.
REQ-017 Port m_break, output, 1: head entry is a break condition.
REQ-018 Port overrun, output, 1: one-cycle pulse when a completed frame is dropped.
REQ-019 Port fifo_level, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Function
REQ-020 uart_rxd SHALL pass through a 2-FF synchronizer that resets to 1; the FSM SHALL use only the synchronized value.
REQ-021 Tick counter: baud_div SHALL be latched at start detect; the counter SHALL count 0..latched value and pulse tick on the terminal count; baud_div=0 means a tick every cycle.
REQ-022 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
REQ-023 IDLE: synchronized line 0 while uart_rx_en=1 SHALL enter START and clear the tick, sample and bit counters.
REQ-024 Each bit SHALL be resolved by a 2-of-3 majority of samples taken at ticks 7, 8 and 9 of its 16-tick bit period.
REQ-025 START: if the majority result is 1 (glitch), the FSM SHALL return to IDLE and push no entry; otherwise it SHALL enter DATA after tick 15.
REQ-026 DATA: SHALL shift in PAYLOAD_BITS bits LSB-first, then enter PARITY when PARITY_EN=1, else STOP.
REQ-027 PARITY: perr SHALL be set when the XOR of the data bits and the parity bit differs from PARITY_ODD.
REQ-028 STOP: ferr SHALL be set if any stop-bit majority is 0.
REQ-029 After the majority of the last stop bit is resolved, the FSM SHALL push {break, ferr, perr, data} and leave STOP without waiting for tick 15.
REQ-030 break SHALL equal data==0 && ferr, with the parity bit sampled 0 when PARITY_EN=1; on break the FSM SHALL enter BRK_WAIT, else IDLE.
REQ-031 BRK_WAIT SHALL hold, with no further push, until the synchronized line is 1, then enter IDLE.
REQ-032 uart_rx_en=0 SHALL force IDLE on the next cycle, abort any frame without a push, and leave the FIFO draining normally.
REQ-033 The FIFO SHALL be first-word-fall-through: m_valid=(level!=0), and head outputs SHALL stay stable while m_valid && !m_ready.
REQ-034 A push SHALL become visible on m_valid one cycle later if the FIFO was empty.
REQ-035 A push SHALL be accepted when level<FIFO_DEPTH, or when level==FIFO_DEPTH with a pop in the same cycle.
REQ-036 A push that is not accepted SHALL leave the FIFO unchanged and pulse overrun for exactly 1 cycle.
REQ-037 A simultaneous push and pop SHALL leave level unchanged; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-038 On resetn=0 the block SHALL enter IDLE with synchronizer=1 and all counters and FIFO pointers=0.
REQ-039 Reset output values SHALL be m_valid=0, m_data=0, m_perr=0, m_ferr=0, m_break=0, overrun=0, fifo_level=0.
REQ-040 Reset mid-frame SHALL discard the partial frame and all FIFO contents.

Verification
REQ-041 baud_div=3, 8N1, byte 0xA5, m_ready=1 -> exactly one m_valid beat with m_data=0xA5 and perr=ferr=break=0.
REQ-042 PARITY_EN=1, PARITY_ODD=0, byte 0x03 sent with parity bit 1 -> m_data=0x03, m_perr=1.
REQ-043 Line low for 5 ticks, then high -> no push, FSM back in IDLE, fifo_level=0.
REQ-044 Line held low for 12 bit times, then high -> one entry with data=0x00, ferr=1, break=1, and no second entry.
REQ-045 FIFO_DEPTH=4, m_ready=0, bytes 0x11..0x15 -> fifo_level=4, one overrun pulse, pops return 0x11, 0x12, 0x13, 0x14.
REQ-046 resetn pulsed during bit 4 of a frame, with 2 entries queued -> fifo_level=0, m_valid=0, next clean frame received correctly.

Source files
------------

// File: rtl/uart_rx_os.sv
// UART receiver with 16x oversampling, 2-of-3 majority voting, optional parity,
// 1 or 2 stop bits, break detection and a first-word-fall-through receive FIFO.
//
// Output handshake: an entry is offered while m_valid is high and is consumed on
// any rising clk edge where m_valid && m_ready; the head fields hold steady until
// that edge. Each FIFO entry carries {break, ferr, perr, data}.
module uart_rx_os #(
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int DIV_W        = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          uart_rxd,
  input  logic                          uart_rx_en,
  input  logic [DIV_W-1:0]              baud_div,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [PAYLOAD_BITS-1:0]       m_data,
  output logic                          m_perr,
  output logic                          m_ferr,
  output logic                          m_break,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [2:0]                    dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = PAYLOAD_BITS + 3;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_DATA     = 3'd2;
  localparam logic [2:0] S_PARITY   = 3'd3;
  localparam logic [2:0] S_STOP     = 3'd4;
  localparam logic [2:0] S_BRK_WAIT = 3'd5;

  // Synchronizer and receive-side registers
  logic                    rxd_meta_q, rxd_sync_q;
  logic [2:0]              state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [DIV_W-1:0]        cnt_q, cnt_d;
  logic [3:0]              samp_q, samp_d;
  logic [2:0]              bit_q, bit_d;
  logic [1:0]              smp_q, smp_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    par_q, par_d;
  logic                    ferr_q, ferr_d;

  logic                    rx;
  logic                    active;
  logic                    tick;
  logic                    maj;
  logic                    resolve;
  logic                    bit_end;
  logic                    fin_ferr;
  logic                    fin_perr;
  logic                    fin_brk;
  logic                    push;
  logic [EW-1:0]           push_entry;

  // FIFO registers
  logic [EW-1:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]           level_q;
  logic                    overrun_q;
  logic                    pop;
  logic                    full;
  logic                    accept;
  logic [EW-1:0]           head;

  assign rx      = rxd_sync_q;
  assign active  = (state_q == S_START) || (state_q == S_DATA) ||
                   (state_q == S_PARITY) || (state_q == S_STOP);
  assign tick    = active && (cnt_q == div_q);
  // Third sample is the live synchronized value at tick 9.
  assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx) | (smp_q[1] & rx);
  assign resolve = tick && (samp_q == 4'd9);
  assign bit_end = tick && (samp_q == 4'd15);

  // Entry fields evaluated when the last stop bit resolves.
  assign fin_ferr = ferr_q | ~maj;
  assign fin_perr = (PARITY_EN != 0) && (((^data_q) ^ par_q) != (PARITY_ODD != 0));
  assign fin_brk  = (data_q == '0) && fin_ferr && ((PARITY_EN == 0) || !par_q);
  assign push_entry = {fin_brk, fin_ferr, fin_perr, data_q};

  assign dbg_state_o = state_q;

  // 2-FF synchronizer on the serial line, idling high
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
    end
  end

  // Receive FSM next-state, tick/sample/bit counters and frame assembly
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = '0;
    samp_d  = samp_q;
    bit_d   = bit_q;
    smp_d   = smp_q;
    data_d  = data_q;
    par_d   = par_q;
    ferr_d  = ferr_q;
    push    = 1'b0;

    if (active) begin
      cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
      if (tick) begin
        samp_d = samp_q + 4'd1;
        if (samp_q == 4'd7) smp_d[0] = rx;
        if (samp_q == 4'd8) smp_d[1] = rx;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (uart_rx_en && !rx) begin
          state_d = S_START;
          div_d   = baud_div;
          cnt_d   = '0;
          samp_d  = 4'd0;
          bit_d   = 3'd0;
          par_d   = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (resolve && maj) begin
          state_d = S_IDLE;
        end else if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (resolve) data_d = {maj, data_q[PAYLOAD_BITS-1:1]};
        if (bit_end) begin
          if (bit_q == 3'(PAYLOAD_BITS - 1)) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (resolve) par_d = maj;
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = 3'd0;
        end
      end
      S_STOP: begin
        if (resolve) begin
          if (!maj) ferr_d = 1'b1;
          // Leave as soon as the last stop bit is known so a new start edge
          // arriving early in the next frame is not missed.
          if (bit_q == 3'(STOP_BITS - 1)) begin
            push    = 1'b1;
            state_d = fin_brk ? S_BRK_WAIT : S_IDLE;
          end
        end else if (bit_end) begin
          bit_d = bit_q + 3'd1;
        end
      end
      S_BRK_WAIT: begin
        if (rx) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!uart_rx_en) begin
      state_d = S_IDLE;
      push    = 1'b0;
    end
  end

  // Receive FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      samp_q  <= '0;
      bit_q   <= '0;
      smp_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      smp_q   <= smp_d;
      data_q  <= data_d;
      par_q   <= par_d;
      ferr_q  <= ferr_d;
    end
  end

  assign pop    = m_valid && m_ready;
  assign full   = (level_q == LW'(FIFO_DEPTH));
  assign accept = push && (!full || pop);
  assign head   = mem[rd_ptr_q];

  // FIFO storage; contents are only visible through the valid-gated head
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= push_entry;
  end

  // FIFO pointers, occupancy and overrun pulse
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
      if (accept && !pop)      level_q <= level_q + LW'(1);
      else if (!accept && pop) level_q <= level_q - LW'(1);
      overrun_q <= push && !accept;
    end
  end

  assign m_valid    = (level_q != '0);
  assign m_data     = m_valid ? head[PAYLOAD_BITS-1:0] : '0;
  assign m_perr     = m_valid & head[PAYLOAD_BITS];
  assign m_ferr     = m_valid & head[PAYLOAD_BITS+1];
  assign m_break    = m_valid & head[PAYLOAD_BITS+2];
  assign overrun    = overrun_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: dut0 is 8N1 with a 4-entry FIFO, dut1 is 8E1.
module tb_uart_rx_os;

  localparam int BIT = 64; // baud_div=3 -> 4 clk per tick, 16 ticks per bit

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn = 1'b0;

  logic        rxd0 = 1'b1, rxd1 = 1'b1;
  logic        rx_en = 1'b1;
  logic [15:0] baud_div = 16'd3;

  logic        m_valid0, m_ready0 = 1'b0, m_perr0, m_ferr0, m_break0, overrun0;
  logic [7:0]  m_data0;
  logic [2:0]  fifo_level0, state0;
  logic        m_valid1, m_ready1 = 1'b0, m_perr1, m_ferr1, m_break1, overrun1;
  logic [7:0]  m_data1;
  logic [4:0]  fifo_level1;
  logic [2:0]  state1;

  int cmp_count  = 0;
  int fail_count = 0;

  uart_rx_os #(.PAYLOAD_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1),
               .DIV_W(16), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd0), .uart_rx_en(rx_en),
    .baud_div(baud_div), .m_valid(m_valid0), .m_ready(m_ready0),
    .m_data(m_data0), .m_perr(m_perr0), .m_ferr(m_ferr0), .m_break(m_break0),
    .overrun(overrun0), .fifo_level(fifo_level0), .dbg_state_o(state0));

  uart_rx_os #(.PAYLOAD_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1),
               .DIV_W(16), .FIFO_DEPTH(16)) dut1 (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd1), .uart_rx_en(rx_en),
    .baud_div(baud_div), .m_valid(m_valid1), .m_ready(m_ready1),
    .m_data(m_data1), .m_perr(m_perr1), .m_ferr(m_ferr1), .m_break(m_break1),
    .overrun(overrun1), .fifo_level(fifo_level1), .dbg_state_o(state1));

  // Observed output beats {break, ferr, perr, data}, and overrun pulse counts
  logic [10:0] cap0_q[$];
  logic [10:0] cap1_q[$];
  logic [10:0] exp_q[$];
  int ovr0 = 0;

  always @(negedge clk) begin
    if (resetn && m_valid0 && m_ready0) cap0_q.push_back({m_break0, m_ferr0, m_perr0, m_data0});
    if (resetn && m_valid1 && m_ready1) cap1_q.push_back({m_break1, m_ferr1, m_perr1, m_data1});
    if (overrun0) ovr0++;
  end

  // Driver tasks: all stimulus changes land 1 time unit after a rising edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int ch, input logic v, input int n);
    if (ch == 0) rxd0 = v;
    else         rxd1 = v;
    cyc(n);
  endtask

  task automatic send0(input logic [7:0] d);
    drive(0, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(0, d[i], BIT);
    drive(0, 1'b1, BIT);
  endtask

  task automatic send1(input logic [7:0] d, input logic p);
    drive(1, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(1, d[i], BIT);
    drive(1, p, BIT);
    drive(1, 1'b1, BIT);
  endtask

  task automatic test_reset();
    logic [10:0] head;
    resetn = 1'b0;
    cyc(4);
    resetn = 1'b1;
    cyc(2);
    head = {m_break0, m_ferr0, m_perr0, m_data0};
    cmp_count++; if (m_valid0 !== 1'b0) begin $display("FAIL reset_valid: got %b expected 0", m_valid0); fail_count++; end
    cmp_count++; if (head !== 11'h000) begin $display("FAIL reset_head: got %h expected 000", head); fail_count++; end
    cmp_count++; if (overrun0 !== 1'b0) begin $display("FAIL reset_overrun: got %b expected 0", overrun0); fail_count++; end
    cmp_count++; if (fifo_level0 !== 3'd0) begin $display("FAIL reset_level: got %0d expected 0", fifo_level0); fail_count++; end
    cmp_count++; if (state0 !== 3'd0) begin $display("FAIL reset_state: got %0d expected 0", state0); fail_count++; end
    cmp_count++; if (m_valid1 !== 1'b0 || fifo_level1 !== 5'd0) begin $display("FAIL reset_dut1: got valid %b level %0d expected 0 0", m_valid1, fifo_level1); fail_count++; end
  endtask

  task automatic test_basic();
    logic [10:0] got;
    m_ready0 = 1'b1;
    cap0_q.delete();
    send0(8'hA5);
    cyc(20);
    cmp_count++; if (cap0_q.size() != 1) begin $display("FAIL basic_count: got %0d expected 1", cap0_q.size()); fail_count++; end
    got = (cap0_q.size() > 0) ? cap0_q.pop_front() : 11'hxxx;
    cmp_count++; if (got !== 11'h0A5) begin $display("FAIL basic_a5: got %h expected 0a5", got); fail_count++; end
    cap0_q.delete();
    send0(8'h3C);
    cyc(20);
    got = (cap0_q.size() > 0) ? cap0_q.pop_front() : 11'hxxx;
    cmp_count++; if (got !== 11'h03C) begin $display("FAIL basic_3c: got %h expected 03c", got); fail_count++; end
  endtask

  task automatic test_back_to_back();
    logic [10:0] got;
    m_ready0 = 1'b1;
    cap0_q.delete();
    send0(8'h01);
    send0(8'h80);
    cyc(20);
    cmp_count++; if (cap0_q.size() != 2) begin $display("FAIL b2b_count: got %0d expected 2", cap0_q.size()); fail_count++; end
    got = (cap0_q.size() > 0) ? cap0_q.pop_front() : 11'hxxx;
    cmp_count++; if (got !== 11'h001) begin $display("FAIL b2b_first: got %h expected 001", got); fail_count++; end
    got = (cap0_q.size() > 0) ? cap0_q.pop_front() : 11'hxxx;
    cmp_count++; if (got !== 11'h080) begin $display("FAIL b2b_second: got %h expected 080", got); fail_count++; end
  endtask

  task automatic test_parity();
    logic [10:0] got;
    m_ready1 = 1'b1;
    cap1_q.delete();
    // 0x03 has two ones; a parity bit of 1 breaks even parity
    send1(8'h03, 1'b1);
    // 0x07 has three ones; a parity bit of 1 is correct even parity
    send1(8'h07, 1'b1);
    cyc(20);
    cmp_count++; if (cap1_q.size() != 2) begin $display("FAIL parity_count: got %0d expected 2", cap1_q.size()); fail_count++; end
    got = (cap1_q.size() > 0) ? cap1_q.pop_front() : 11'hxxx;
    cmp_count++; if (got !== 11'h103) begin $display("FAIL parity_err: got %h expected 103", got); fail_count++; end
    got = (cap1_q.size() > 0) ? cap1_q.pop_front() : 11'hxxx;
    cmp_count++; if (got !== 11'h007) begin $display("FAIL parity_ok: got %h expected 007", got); fail_count++; end
  endtask

  task automatic test_glitch();
    m_ready0 = 1'b1;
    cap0_q.delete();
    drive(0, 1'b0, 10);
    cmp_count++; if (state0 !== 3'd1) begin $display("FAIL glitch_start: got state %0d expected 1", state0); fail_count++; end
    drive(0, 1'b0, 10);
    drive(0, 1'b1, 100);
    cmp_count++; if (cap0_q.size() != 0) begin $display("FAIL glitch_push: got %0d entries expected 0", cap0_q.size()); fail_count++; end
    cmp_count++; if (state0 !== 3'd0) begin $display("FAIL glitch_idle: got state %0d expected 0", state0); fail_count++; end
    cmp_count++; if (fifo_level0 !== 3'd0) begin $display("FAIL glitch_level: got %0d expected 0", fifo_level0); fail_count++; end
  endtask

  task automatic test_break();
    logic [10:0] got;
    m_ready0 = 1'b1;
    cap0_q.delete();
    drive(0, 1'b0, 12 * BIT);
    cmp_count++; if (state0 !== 3'd5) begin $display("FAIL break_wait: got state %0d expected 5", state0); fail_count++; end
    got = (cap0_q.size() > 0) ? cap0_q.pop_front() : 11'hxxx;
    cmp_count++; if (got !== 11'h600) begin $display("FAIL break_entry: got %h expected 600", got); fail_count++; end
    drive(0, 1'b1, 200);
    cmp_count++; if (cap0_q.size() != 0) begin $display("FAIL break_second: got %0d extra entries expected 0", cap0_q.size()); fail_count++; end
    cmp_count++; if (state0 !== 3'd0) begin $display("FAIL break_idle: got state %0d expected 0", state0); fail_count++; end
  endtask

  task automatic test_overrun();
    logic [10:0] got;
    m_ready0 = 1'b0;
    cap0_q.delete();
    exp_q.delete();
    ovr0 = 0;
    for (int i = 0; i < 5; i++) send0(8'h11 + 8'(i));
    cyc(20);
    cmp_count++; if (fifo_level0 !== 3'd4) begin $display("FAIL ovr_level: got %0d expected 4", fifo_level0); fail_count++; end
    cmp_count++; if (ovr0 != 1) begin $display("FAIL ovr_pulses: got %0d expected 1", ovr0); fail_count++; end
    cmp_count++; if (m_valid0 !== 1'b1 || m_data0 !== 8'h11) begin $display("FAIL ovr_head: got valid %b data %h expected 1 11", m_valid0, m_data0); fail_count++; end
    for (int i = 0; i < 4; i++) exp_q.push_back(11'h011 + 11'(i));
    m_ready0 = 1'b1;
    cyc(10);
    m_ready0 = 1'b0;
    cmp_count++; if (cap0_q.size() != 4) begin $display("FAIL ovr_pops: got %0d expected 4", cap0_q.size()); fail_count++; end
    while (exp_q.size() > 0) begin
      got = (cap0_q.size() > 0) ? cap0_q.pop_front() : 11'hxxx;
      cmp_count++; if (got !== exp_q[0]) begin $display("FAIL ovr_order: got %h expected %h", got, exp_q[0]); fail_count++; end
      void'(exp_q.pop_front());
    end
    cmp_count++; if (fifo_level0 !== 3'd0) begin $display("FAIL ovr_drained: got %0d expected 0", fifo_level0); fail_count++; end
  endtask

  task automatic test_reset_mid();
    logic [10:0] got;
    m_ready0 = 1'b0;
    send0(8'h21);
    send0(8'h22);
    cyc(10);
    cmp_count++; if (fifo_level0 !== 3'd2) begin $display("FAIL rmid_queued: got %0d expected 2", fifo_level0); fail_count++; end
    // Frame 0x10: start, bits 0..3 low, then reset halfway through bit 4 (high)
    drive(0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(0, 1'b0, BIT);
    drive(0, 1'b1, BIT / 2);
    resetn = 1'b0;
    cyc(2);
    resetn = 1'b1;
    cyc(1);
    cmp_count++; if (fifo_level0 !== 3'd0 || m_valid0 !== 1'b0) begin $display("FAIL rmid_flush: got level %0d valid %b expected 0 0", fifo_level0, m_valid0); fail_count++; end
    drive(0, 1'b1, 200);
    cmp_count++; if (state0 !== 3'd0 || fifo_level0 !== 3'd0) begin $display("FAIL rmid_idle: got state %0d level %0d expected 0 0", state0, fifo_level0); fail_count++; end
    m_ready0 = 1'b1;
    cap0_q.delete();
    send0(8'h5A);
    cyc(20);
    cmp_count++; if (cap0_q.size() != 1) begin $display("FAIL rmid_count: got %0d expected 1", cap0_q.size()); fail_count++; end
    got = (cap0_q.size() > 0) ? cap0_q.pop_front() : 11'hxxx;
    cmp_count++; if (got !== 11'h05A) begin $display("FAIL rmid_clean: got %h expected 05a", got); fail_count++; end
  endtask

  // Watchdog bounding the whole run
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    fail_count++;
    $display("End of test - %0d assertions evaluated, %0d failures", cmp_count, fail_count);
    $fatal(1, "watchdog expired");
  end

  // Test sequence and final report
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_parity();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", cmp_count, fail_count);
    $finish;
  end

endmodule
